// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared types and sizes for the FFT frame sequencer
package fft_ctrl_pkg;
  localparam int FFT_N = 256;
  localparam int FFT_LOG2 = 8;
  localparam int SHIFT_W = 4;
  localparam int TO_W = 10;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, UNLOAD, DONE} fft_ctrl_state_t;
endpackage

// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: request, source, core and output-bin signals of one frame controller
interface fft_frame_ctrl_if;
  import fft_ctrl_pkg::*;
  logic frame_req, frame_ack, busy, src_en, fft_start, fft_ed, fft_rdy;
  logic out_valid, out_last, frame_done, frame_ovf, err_timeout;
  logic [FFT_LOG2-1:0] src_addr, fft_addr, out_bin;
  logic [SHIFT_W-1:0] fft_shift;
  logic [1:0] fft_ovf;
  modport master (
    input frame_req, fft_rdy, fft_ovf, fft_addr,
    output frame_ack, busy, src_addr, src_en, fft_start, fft_ed, fft_shift,
    output out_valid, out_bin, out_last, frame_done, frame_ovf, err_timeout
  );
  modport slave (
    output frame_req, fft_rdy, fft_ovf, fft_addr,
    input frame_ack, busy, src_addr, src_en, fft_start, fft_ed, fft_shift,
    input out_valid, out_bin, out_last, frame_done, frame_ovf, err_timeout
  );
endinterface

// File: rtl/fft_ctrl_cnt.sv
// fft_ctrl_cnt: loadable up-counter with terminal-count flag
module fft_ctrl_cnt #(
  parameter int W = 8,
  parameter logic [W-1:0] TC = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         tc
);
  // load wins over count; wraps naturally at 2^W
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (ld) q <= d;
    else if (en) q <= q + 1'b1;
  assign tc = q == TC;
endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: FFT256 frame sequencer; define FFT_OVF_RETRY_EN to replay overflowed frames with a larger shift
module fft_frame_ctrl import fft_ctrl_pkg::*; #(
  parameter logic [SHIFT_W-1:0] SHIFT_INIT = 4'b0010,
  parameter int TIMEOUT = 1023
) (
  input logic clk,
  input logic rst,
  fft_frame_ctrl_if.master bus
);
  fft_ctrl_state_t st, nxt;
  logic pend, accept, retry, cap, cnt_tc, to_tc;
  logic [FFT_LOG2-1:0] cnt;
  logic [TO_W-1:0] to_q_unused;
  // one counter serves as sample address in LOAD and bin index while unloading
  fft_ctrl_cnt #(.W(FFT_LOG2)) u_cnt (
    .clk(clk), .rst(rst), .ld(accept | retry), .en(st == LOAD || cap),
    .d('0), .q(cnt), .tc(cnt_tc)
  );
  fft_ctrl_cnt #(.W(TO_W), .TC(TO_W'(TIMEOUT - 1))) u_to (
    .clk(clk), .rst(rst), .ld(st != WAIT), .en(1'b1),
    .d('0), .q(to_q_unused), .tc(to_tc)
  );
  assign cap = (st == WAIT && bus.fft_rdy) || st == UNLOAD;
  assign accept = (st == IDLE || (st == DONE && !retry)) && (bus.frame_req || pend);
`ifdef FFT_OVF_RETRY_EN
  assign retry = st == DONE && bus.frame_ovf && bus.fft_shift != '1;
`else
  assign retry = 1'b0;
`endif
  assign bus.src_addr = cnt;
  // next state; the RDY cycle itself carries bin 0, so WAIT hands straight to UNLOAD
  always_comb
    nxt = st == IDLE   ? (accept ? LOAD : IDLE) :
          st == LOAD   ? (cnt_tc ? WAIT : LOAD) :
          st == WAIT   ? (bus.fft_rdy ? UNLOAD : to_tc ? IDLE : WAIT) :
          st == UNLOAD ? (cnt_tc ? DONE : UNLOAD) :
          (accept || retry) ? LOAD : IDLE;
  // state, pending flag, sticky flags and all registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      pend <= 1'b0;
      bus.frame_ack <= 1'b0;
      bus.busy <= 1'b0;
      bus.fft_ed <= 1'b0;
      bus.src_en <= 1'b0;
      bus.fft_start <= 1'b0;
      bus.fft_shift <= SHIFT_INIT;
      bus.out_valid <= 1'b0;
      bus.out_bin <= '0;
      bus.out_last <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_ovf <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      st <= nxt;
      pend <= accept ? 1'b0 : pend | (bus.frame_req && st inside {LOAD, WAIT, UNLOAD});
      bus.frame_ack <= accept;
      bus.busy <= nxt != IDLE;
      bus.fft_ed <= nxt != IDLE;
      bus.src_en <= nxt == LOAD;
      bus.fft_start <= nxt == LOAD && st != LOAD;
      bus.out_valid <= cap;
      bus.out_bin <= cap ? bus.fft_addr : '0;
      bus.out_last <= cap && cnt_tc;
      bus.frame_done <= st == DONE && !retry;
      bus.frame_ovf <= (accept || retry) ? 1'b0 : bus.frame_ovf | (cap && |bus.fft_ovf);
      bus.err_timeout <= accept ? 1'b0 : bus.err_timeout | (st == WAIT && !bus.fft_rdy && to_tc);
`ifdef FFT_OVF_RETRY_EN
      bus.fft_shift <= accept ? SHIFT_INIT : retry ? bus.fft_shift + 1'b1 : bus.fft_shift;
`else
      bus.fft_shift <= SHIFT_INIT;
`endif
    end
endmodule
